// File: rtl/dmem_sequencer.sv
// dmem_sequencer: walks every (iteration, layer, address) tuple of the layered
// decoder D-memory. It issues one read per cycle and replays each read as a
// write-back PIPESTAGES cycles later. It also handles early termination, the
// drain of the write pipeline and the completion pulse.
module dmem_sequencer #(
    parameter int ADDRESSWIDTH = 5,
    parameter int ROWDEPTH     = 20,
    parameter int LAYERS       = 2,
    parameter int PIPESTAGES   = 14,
    parameter int MAXITRS      = 10,
    parameter int ITRWIDTH     = 4,
    parameter int LAYERGAP     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    terminate,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] rd_address,
    output logic                    rd_layer,
    output logic                    wr_en,
    output logic [ADDRESSWIDTH-1:0] wr_address,
    output logic                    wr_layer,
    output logic                    first_itr,
    output logic                    last_p,
    output logic [ITRWIDTH-1:0]     itr_count,
    output logic                    busy,
    output logic                    done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // The gap counter only ever holds LAYERGAP-1 down to 0.
    localparam int GAPW = (LAYERGAP > 1) ? $clog2(LAYERGAP) : 1;

    localparam logic [ADDRESSWIDTH-1:0] ADDR_LAST  = ADDRESSWIDTH'(ROWDEPTH - 1);
    localparam logic                    LAYER_LAST = 1'(LAYERS - 1);
    localparam logic [ITRWIDTH-1:0]     ITR_LAST   = ITRWIDTH'(MAXITRS - 1);
    localparam logic [GAPW-1:0]         GAP_LOAD   = GAPW'((LAYERGAP > 0) ? (LAYERGAP - 1) : 0);

    logic [2:0]              r_state;
    logic [ADDRESSWIDTH-1:0] r_addr;
    logic                    r_layer;
    logic [ITRWIDTH-1:0]     r_itr;
    logic                    r_term;
    logic [GAPW-1:0]         r_gap_cnt;

    // Write-back pipeline: stage 0 takes the read issued this cycle, and the
    // last stage drives the write port.
    logic [PIPESTAGES-1:0]                   r_vld_p;
    logic [PIPESTAGES-1:0][ADDRESSWIDTH-1:0] r_addr_p;
    logic [PIPESTAGES-1:0]                   r_layer_p;

    logic w_rd_en;
    logic w_layer_end;
    logic w_term;
    logic w_final_layer;
    logic w_to_drain;
    logic w_itr_inc;
    logic w_pipe_busy;

    assign w_rd_en       = (r_state == S_RUN);
    assign w_layer_end   = w_rd_en && (r_addr == ADDR_LAST);
    // A terminate that arrives in the layer-end cycle itself also stops the run.
    assign w_term        = r_term | terminate;
    assign w_final_layer = (r_itr == ITR_LAST) && (r_layer == LAYER_LAST);
    assign w_to_drain    = w_layer_end && (w_final_layer || w_term);
    // Count the iteration as started-and-finished either at its natural end or
    // when terminate cuts it short after a non-final layer.
    assign w_itr_inc     = w_layer_end && ((r_layer == LAYER_LAST) || w_to_drain);

    // Check whether any write is still in flight behind the one now leaving the pipeline.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < PIPESTAGES - 1; i++) begin
            w_pipe_busy = w_pipe_busy | r_vld_p[i];
        end
    end

    // Sequencing FSM with the address/layer/iteration counters and the terminate latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_layer   <= 1'b0;
            r_itr     <= '0;
            r_term    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // itr_count keeps the last run's result until a new start.
                    r_term <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_addr  <= '0;
                        r_layer <= 1'b0;
                        r_itr   <= '0;
                    end
                end
                S_RUN: begin
                    if (terminate) begin
                        r_term <= 1'b1;
                    end
                    if (r_addr == ADDR_LAST) begin
                        r_addr  <= '0;
                        r_layer <= (r_layer == LAYER_LAST) ? 1'b0 : 1'b1;
                        if (w_itr_inc) begin
                            r_itr <= r_itr + ITRWIDTH'(1);
                        end
                        if (w_to_drain) begin
                            r_state <= S_DRAIN;
                        end else if (LAYERGAP > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end
                    end else begin
                        r_addr <= r_addr + ADDRESSWIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (terminate) begin
                        r_term <= 1'b1;
                    end
                    if (w_term) begin
                        // No new layer starts once terminate is seen. A gap in
                        // the middle of an iteration has not counted it yet.
                        r_state <= S_DRAIN;
                        if (r_layer != 1'b0) begin
                            r_itr <= r_itr + ITRWIDTH'(1);
                        end
                    end else if (r_gap_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAPW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write pipeline valid bits: cleared on reset so no pending write survives it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd_en;
            for (int i = 1; i < PIPESTAGES; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    // Write pipeline address/layer payload; outputs are masked by the valid bit.
    always_ff @(posedge clk) begin
        r_addr_p[0]  <= rd_address;
        r_layer_p[0] <= rd_layer;
        for (int i = 1; i < PIPESTAGES; i++) begin
            r_addr_p[i]  <= r_addr_p[i-1];
            r_layer_p[i] <= r_layer_p[i-1];
        end
    end

    assign rd_en      = w_rd_en;
    assign rd_address = w_rd_en ? r_addr : '0;
    assign rd_layer   = w_rd_en & r_layer;
    assign wr_en      = r_vld_p[PIPESTAGES-1];
    assign wr_address = wr_en ? r_addr_p[PIPESTAGES-1] : '0;
    assign wr_layer   = wr_en & r_layer_p[PIPESTAGES-1];
    assign first_itr  = w_rd_en && (r_itr == '0);
    assign last_p     = w_layer_end;
    assign itr_count  = r_itr;
    assign busy       = (r_state == S_RUN) || (r_state == S_GAP) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_dmem_sequencer.sv
// Scoreboard bench for dmem_sequencer. Instance 0 uses the default parameters,
// and instance 1 uses LAYERGAP=3 and MAXITRS=1.
`timescale 1ns/1ps
module tb_dmem_sequencer;

    typedef struct { int cyc; int addr; int layer; int first; int lastp; int itr; } rd_t;
    typedef struct { int cyc; int addr; int layer; } wr_t;
    typedef struct { int cyc; int itr; } dn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_i[2];
    logic       start_i[2];
    logic       term_i[2];
    logic       rd_en_o[2];
    logic       rd_layer_o[2];
    logic       wr_en_o[2];
    logic       wr_layer_o[2];
    logic       first_o[2];
    logic       lastp_o[2];
    logic       busy_o[2];
    logic       done_o[2];
    logic [4:0] rd_addr_o[2];
    logic [4:0] wr_addr_o[2];
    logic [3:0] itr_o[2];

    dmem_sequencer #(.ADDRESSWIDTH(5), .ROWDEPTH(20), .LAYERS(2), .PIPESTAGES(14),
                     .MAXITRS(10), .ITRWIDTH(4), .LAYERGAP(0)) u_dut0 (
        .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .terminate(term_i[0]),
        .rd_en(rd_en_o[0]), .rd_address(rd_addr_o[0]), .rd_layer(rd_layer_o[0]),
        .wr_en(wr_en_o[0]), .wr_address(wr_addr_o[0]), .wr_layer(wr_layer_o[0]),
        .first_itr(first_o[0]), .last_p(lastp_o[0]), .itr_count(itr_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    dmem_sequencer #(.ADDRESSWIDTH(5), .ROWDEPTH(20), .LAYERS(2), .PIPESTAGES(14),
                     .MAXITRS(1), .ITRWIDTH(4), .LAYERGAP(3)) u_dut1 (
        .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .terminate(term_i[1]),
        .rd_en(rd_en_o[1]), .rd_address(rd_addr_o[1]), .rd_layer(rd_layer_o[1]),
        .wr_en(wr_en_o[1]), .wr_address(wr_addr_o[1]), .wr_layer(wr_layer_o[1]),
        .first_itr(first_o[1]), .last_p(lastp_o[1]), .itr_count(itr_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    rd_t rdq[$];
    wr_t wrq[$];
    dn_t dnq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int act      = 0;
    bit mon_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, none expected (cycle %0d)", name, cyc);
    endtask

    // Expected reads/writes of one run, written from the addressing rules:
    // 20 addresses per layer, 2 layers per iteration, a write 14 cycles after each read.
    task automatic gen_run(input int base, input int maxitr, input int gap, input int term_rel);
        int  c;
        bit  stop;
        rd_t r;
        wr_t w;
        c    = 1;
        stop = 1'b0;
        for (int it = 0; it < maxitr && !stop; it++) begin
            for (int ly = 0; ly < 2 && !stop; ly++) begin
                for (int a = 0; a < 20; a++) begin
                    r.cyc = base + c; r.addr = a; r.layer = ly;
                    r.first = (it == 0) ? 1 : 0; r.lastp = (a == 19) ? 1 : 0; r.itr = it;
                    rdq.push_back(r);
                    w.cyc = base + c + 14; w.addr = a; w.layer = ly;
                    wrq.push_back(w);
                    c++;
                end
                if (term_rel > 0 && term_rel < c) stop = 1'b1;
                else if (!(it == maxitr - 1 && ly == 1)) c += gap;
            end
        end
    endtask

    task automatic push_done(input int at, input int itr);
        dn_t d;
        d.cyc = at;
        d.itr = itr;
        dnq.push_back(d);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while ((rdq.size() != 0 || wrq.size() != 0 || dnq.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", rdq.size() + wrq.size() + dnq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk({tag, "_rd_en"}, rd_en_o[d], 0);
        chk({tag, "_rd_addr"}, rd_addr_o[d], 0);
        chk({tag, "_rd_layer"}, rd_layer_o[d], 0);
        chk({tag, "_wr_en"}, wr_en_o[d], 0);
        chk({tag, "_wr_addr"}, wr_addr_o[d], 0);
        chk({tag, "_wr_layer"}, wr_layer_o[d], 0);
        chk({tag, "_first_itr"}, first_o[d], 0);
        chk({tag, "_last_p"}, lastp_o[d], 0);
        chk({tag, "_itr_count"}, itr_o[d], 0);
        chk({tag, "_busy"}, busy_o[d], 0);
        chk({tag, "_done"}, done_o[d], 0);
    endtask

    rd_t mr;
    wr_t mw;
    dn_t md;

    // Monitor: pops the scoreboard whenever the active DUT presents a read, write or done.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                if (d == act) begin
                    if (rd_en_o[d]) begin
                        if (rdq.size() == 0) fail_evt("rd_en");
                        else begin
                            mr = rdq.pop_front();
                            chk("rd_cycle", cyc, mr.cyc);
                            chk("rd_address", rd_addr_o[d], mr.addr);
                            chk("rd_layer", rd_layer_o[d], mr.layer);
                            chk("first_itr", first_o[d], mr.first);
                            chk("last_p", lastp_o[d], mr.lastp);
                            chk("rd_itr_count", itr_o[d], mr.itr);
                            chk("rd_busy", busy_o[d], 1);
                        end
                    end
                    if (wr_en_o[d]) begin
                        if (wrq.size() == 0) fail_evt("wr_en");
                        else begin
                            mw = wrq.pop_front();
                            chk("wr_cycle", cyc, mw.cyc);
                            chk("wr_address", wr_addr_o[d], mw.addr);
                            chk("wr_layer", wr_layer_o[d], mw.layer);
                            chk("wr_busy", busy_o[d], 1);
                        end
                    end
                    if (done_o[d]) begin
                        if (dnq.size() == 0) fail_evt("done");
                        else begin
                            md = dnq.pop_front();
                            chk("done_cycle", cyc, md.cyc);
                            chk("done_itr_count", itr_o[d], md.itr);
                            chk("done_busy", busy_o[d], 0);
                        end
                    end
                end else if (rd_en_o[d] || wr_en_o[d] || done_o[d]) begin
                    fail_evt("inactive_dut_activity");
                end
            end
        end
    end

    int base;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b0; start_i[d] = 1'b0; term_i[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero(0, "reset0");
        chk_all_zero(1, "reset1");
        rst_i[0] = 1'b1;
        rst_i[1] = 1'b1;
        mon_on   = 1'b1;
        repeat (2) @(negedge clk);

        // Default run: reads 1..400, writes 15..414, done at 415 with 10 iterations.
        act  = 0;
        base = cyc;
        gen_run(base, 10, 0, -1);
        push_done(base + 415, 10);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        chk("busy_cycle1", busy_o[0], 1);
        wait_cyc(base + 414);
        chk("busy_last_write", busy_o[0], 1);
        wait_cyc(base + 416);
        chk("itr_held_after_done", itr_o[0], 10);
        wait_empty(50);

        // Terminate in cycle 25: reads stop at 40, done at 55, itr_count 1.
        base = cyc;
        gen_run(base, 10, 0, 25);
        push_done(base + 55, 1);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        wait_cyc(base + 25);
        term_i[0] = 1'b1;
        @(negedge clk);
        term_i[0] = 1'b0;
        wait_empty(100);

        // Terminate in IDLE, start during RUN and DRAIN, terminate in DRAIN, start in DONE:
        // all ignored, so the run is identical to the default one.
        term_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        term_i[0] = 1'b0;
        base = cyc;
        gen_run(base, 10, 0, -1);
        push_done(base + 415, 10);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_cyc(base + ((k == 0) ? 5 : (k == 1) ? 200 : 405));
            start_i[0] = 1'b1;
            term_i[0]  = (k == 2);
            @(negedge clk);
            start_i[0] = 1'b0;
            term_i[0]  = 1'b0;
        end
        // start held through DONE (cycle 415, ignored) into IDLE (cycle 416, taken).
        wait_cyc(base + 415);
        start_i[0] = 1'b1;
        @(negedge clk);
        chk("itr_in_idle_before_restart", itr_o[0], 10);
        base = cyc;
        gen_run(base, 10, 0, 25);
        push_done(base + 55, 1);
        @(negedge clk);
        start_i[0] = 1'b0;
        chk("b2b_itr_restart", itr_o[0], 0);
        chk("b2b_first_read", rd_en_o[0], 1);
        wait_cyc(base + 25);
        term_i[0] = 1'b1;
        @(negedge clk);
        term_i[0] = 1'b0;
        wait_empty(100);

        // Reset in cycle 100: nothing is read or written from cycle 101 on.
        base = cyc;
        gen_run(base, 10, 0, -1);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        wait_cyc(base + 100);
        rst_i[0] = 1'b0;
        while (rdq.size() != 0 && rdq[rdq.size()-1].cyc > base + 100) void'(rdq.pop_back());
        while (wrq.size() != 0 && wrq[wrq.size()-1].cyc > base + 100) void'(wrq.pop_back());
        @(negedge clk);
        chk_all_zero(0, "midrun_reset");
        rst_i[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_write_after_reset", wrq.size(), 0);

        // Restart after reset, terminate in layer 0: reads 1..20, done at 35, itr_count 1.
        base = cyc;
        gen_run(base, 10, 0, 10);
        push_done(base + 35, 1);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        chk("restart_itr_zero", itr_o[0], 0);
        wait_cyc(base + 10);
        term_i[0] = 1'b1;
        @(negedge clk);
        term_i[0] = 1'b0;
        wait_empty(100);

        // LAYERGAP=3, MAXITRS=1: reads 1..20 and 24..43, done at 58.
        act  = 1;
        base = cyc;
        gen_run(base, 1, 3, -1);
        push_done(base + 58, 1);
        start_i[1] = 1'b1;
        @(negedge clk);
        start_i[1] = 1'b0;
        wait_cyc(base + 22);
        chk("gap_rd_en_low", rd_en_o[1], 0);
        chk("gap_busy", busy_o[1], 1);
        wait_empty(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
